sblk_shift_pipe: RTL and testbench

//  Parametrised successor to the two-flop sblk1 stage: DEPTH-stage, WIDTH-bit register pipeline.

---
 rtl/sblk_shift_pipe.sv | 119 +++++++++++
 tb/tb_sblk_shift_pipe.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sblk_shift_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : sblk_shift_pipe
//  Description : DEPTH-stage, WIDTH-bit register pipeline with parallel load,
//                rotate, pairwise swap and hold modes. It tracks how many
//                valid entries have been shifted or loaded in, and raises a
//                full flag when every stage holds one.
//  Revision    : 1.0 - initial release
// ============================================================================
module sblk_shift_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic                         load,
    input  logic [WIDTH*DEPTH-1:0]       load_data,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [WIDTH*DEPTH-1:0]       stages,
    output logic [$clog2(DEPTH+1)-1:0]   fill_cnt,
    output logic                         full
);

    localparam int                 c_CNT_W      = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FILL_MAX   = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_FILL_ONE   = c_CNT_W'(1);

    localparam logic [1:0] c_MODE_SHIFT  = 2'b00;
    localparam logic [1:0] c_MODE_ROTATE = 2'b01;
    localparam logic [1:0] c_MODE_SWAP   = 2'b10;

    // Current value of every stage, stage k in element k.
    logic [DEPTH-1:0][WIDTH-1:0] w_stage;
    logic [c_CNT_W-1:0]          r_fill;
    logic [c_CNT_W-1:0]          w_fill_next;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] r_q;
        logic [WIDTH-1:0] w_d;
        logic [WIDTH-1:0] w_shift_src;
        logic [WIDTH-1:0] w_rot_src;
        logic [WIDTH-1:0] w_swap_src;

        // Stage 0 takes the serial input on shift and the tail on rotate;
        // every other stage takes its predecessor in both modes.
        if (k == 0) begin : g_head
            assign w_shift_src = din;
            assign w_rot_src   = w_stage[DEPTH-1];
        end else begin : g_body
            assign w_shift_src = w_stage[k-1];
            assign w_rot_src   = w_stage[k-1];
        end

        // Even stage pairs with the next one, odd stage with the previous;
        // an unpaired last stage (odd DEPTH) keeps its own value.
        if ((k % 2 == 0) && (k + 1 < DEPTH)) begin : g_swap_lo
            assign w_swap_src = w_stage[k+1];
        end else if (k % 2 == 1) begin : g_swap_hi
            assign w_swap_src = w_stage[k-1];
        end else begin : g_swap_tail
            assign w_swap_src = r_q;
        end

        // Next value: load wins over en; HOLD and idle keep the stage.
        always_comb begin
            w_d = r_q;
            if (load) begin
                w_d = load_data[k*WIDTH +: WIDTH];
            end else if (en) begin
                case (mode)
                    c_MODE_SHIFT:  w_d = w_shift_src;
                    c_MODE_ROTATE: w_d = w_rot_src;
                    c_MODE_SWAP:   w_d = w_swap_src;
                    default:       w_d = r_q;
                endcase
            end
        end

        // Stage register; all stages update on the same edge from old values.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_q <= '0;
            end else begin
                r_q <= w_d;
            end
        end

        assign w_stage[k] = r_q;
    end

    // Fill count: jumps to DEPTH on load, counts up on enabled shifts.
    always_comb begin
        w_fill_next = r_fill;
        if (load) begin
            w_fill_next = c_FILL_MAX;
        end else if (en && (mode == c_MODE_SHIFT) && (r_fill != c_FILL_MAX)) begin
            w_fill_next = r_fill + c_FILL_ONE;
        end
    end

    // Fill count register; only reset ever brings it back down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill <= '0;
        end else begin
            r_fill <= w_fill_next;
        end
    end

    assign stages   = w_stage;
    assign dout     = w_stage[DEPTH-1];
    assign fill_cnt = r_fill;
    assign full     = (r_fill == c_FILL_MAX);

endmodule
`default_nettype wire

// File: tb/tb_sblk_shift_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sblk_shift_pipe
//  Description : Self-checking bench for sblk_shift_pipe. Main instance is
//                WIDTH=8/DEPTH=4; a DEPTH=3 instance covers the odd swap tail
//                and a default instance covers the two-flop chain.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sblk_shift_pipe;

    typedef struct packed {
        logic [31:0] st;
        logic [2:0]  fill;
        logic        full;
        logic [7:0]  dout;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Main instance (WIDTH=8, DEPTH=4)
    logic        en = 1'b0, load = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] load_data = '0;
    logic [7:0]  din = '0, dout;
    logic [31:0] stages;
    logic [2:0]  fill_cnt;
    logic        full;

    // Odd-depth instance (WIDTH=8, DEPTH=3)
    logic        en3 = 1'b0, load3 = 1'b0;
    logic [1:0]  mode3 = 2'b00;
    logic [23:0] load_data3 = '0;
    logic [7:0]  din3 = '0, dout3;
    logic [23:0] stages3;
    logic [1:0]  fill_cnt3;
    logic        full3;

    // Default instance (WIDTH=1, DEPTH=2)
    logic        en1 = 1'b0, load1 = 1'b0;
    logic [1:0]  mode1 = 2'b00;
    logic [1:0]  load_data1 = '0;
    logic        din1 = 1'b0, dout1;
    logic [1:0]  stages1;
    logic [1:0]  fill_cnt1;
    logic        full1;

    int n_chk  = 0;
    int n_pass = 0;

    exp_t        sb_q[$];
    logic [31:0] m_st   = '0;
    int          m_fill = 0;

    always #5 clk = ~clk;

    sblk_shift_pipe #(.WIDTH(8), .DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
        .load_data(load_data), .din(din), .dout(dout), .stages(stages),
        .fill_cnt(fill_cnt), .full(full)
    );

    sblk_shift_pipe #(.WIDTH(8), .DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .en(en3), .mode(mode3), .load(load3),
        .load_data(load_data3), .din(din3), .dout(dout3), .stages(stages3),
        .fill_cnt(fill_cnt3), .full(full3)
    );

    sblk_shift_pipe u_dut1 (
        .clk(clk), .rst(rst), .en(en1), .mode(mode1), .load(load1),
        .load_data(load_data1), .din(din1), .dout(dout1), .stages(stages1),
        .fill_cnt(fill_cnt1), .full(full1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one edge on the main instance, push the model's expectation,
    // then pop it and compare once the DUT has taken the edge.
    task automatic step(input string tag, input logic ld, input logic [31:0] ldd,
                        input logic e, input logic [1:0] md, input logic [7:0] d);
        exp_t x;
        load = ld; load_data = ldd; en = e; mode = md; din = d;
        if (ld) begin
            m_st = ldd; m_fill = 4;
        end else if (e) begin
            case (md)
                2'b00: begin
                    m_st = {m_st[23:0], d};
                    if (m_fill < 4) m_fill++;
                end
                2'b01: m_st = {m_st[23:0], m_st[31:24]};
                2'b10: m_st = {m_st[23:16], m_st[31:24], m_st[7:0], m_st[15:8]};
                default: ;
            endcase
        end
        x.st = m_st; x.fill = 3'(m_fill); x.full = (m_fill == 4); x.dout = m_st[31:24];
        sb_q.push_back(x);
        @(posedge clk); #1;
        x = sb_q.pop_front();
        chk({tag, ".st"},   64'(stages),   64'(x.st));
        chk({tag, ".fill"}, 64'(fill_cnt), 64'(x.fill));
        chk({tag, ".full"}, 64'(full),     64'(x.full));
        chk({tag, ".dout"}, 64'(dout),     64'(x.dout));
        load = 1'b0; en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rst.st",    64'(stages),   64'h0);
        chk("rst.fill",  64'(fill_cnt), 64'h0);
        chk("rst.full",  64'(full),     64'h0);
        chk("rst.dout",  64'(dout),     64'h0);
        chk("rst.st3",   64'(stages3),  64'h0);
        chk("rst.st1",   64'(stages1),  64'h0);
        @(posedge clk); #1;

        // 1. shift four bytes in; full only on the fourth edge
        step("t1a", 0, '0, 1, 2'b00, 8'h11);
        step("t1b", 0, '0, 1, 2'b00, 8'h22);
        step("t1c", 0, '0, 1, 2'b00, 8'h33);
        chk("t1.full3", 64'(full), 64'h0);
        step("t1d", 0, '0, 1, 2'b00, 8'h44);
        chk("t1.dout",  64'(dout),   64'h11);
        chk("t1.st",    64'(stages), 64'h11223344);
        chk("t1.full",  64'(full),   64'h1);
        step("t1sat", 0, '0, 1, 2'b00, 8'h55);
        chk("t1.satfill", 64'(fill_cnt), 64'h4);

        // 2. load then rotate
        step("t2ld", 1, 32'h04030201, 0, 2'b00, 8'h00);
        step("t2rot", 0, '0, 1, 2'b01, 8'h99);
        chk("t2.st",   64'(stages),   64'h03020104);
        chk("t2.fill", 64'(fill_cnt), 64'h4);

        // 3. load then swap
        step("t3ld", 1, 32'h04030201, 0, 2'b00, 8'h00);
        step("t3sw", 0, '0, 1, 2'b10, 8'h99);
        chk("t3.st", 64'(stages), 64'h03040102);

        // 4. load beats a same-edge shift
        step("t4", 1, 32'hAABBCCDD, 1, 2'b00, 8'h55);
        chk("t4.st", 64'(stages), 64'hAABBCCDD);

        // 5. idle and HOLD with din toggling
        for (int i = 0; i < 5; i++)
            step("t5", 0, '0, (i % 2 == 1), 2'b11, (i % 2 == 1) ? 8'hFF : 8'h00);
        chk("t5.st",   64'(stages),   64'hAABBCCDD);
        chk("t5.fill", 64'(fill_cnt), 64'h4);

        // 6. reset pulsed mid-shift, away from the clock edge
        rst = 1'b1; @(posedge clk); #3 rst = 1'b0;
        m_st = '0; m_fill = 0;
        step("t6a", 0, '0, 1, 2'b00, 8'h5A);
        step("t6rot", 0, '0, 1, 2'b01, 8'h00);
        step("t6b", 0, '0, 1, 2'b00, 8'hA5);
        step("t6sw", 0, '0, 1, 2'b10, 8'h00);
        #3 rst = 1'b1;
        #1;
        chk("t6.rst.st",   64'(stages),   64'h0);
        chk("t6.rst.fill", 64'(fill_cnt), 64'h0);
        chk("t6.rst.full", 64'(full),     64'h0);
        #1 rst = 1'b0;
        m_st = '0; m_fill = 0;
        @(posedge clk); #1;
        step("t6c", 0, '0, 1, 2'b00, 8'h01);
        step("t6d", 0, '0, 1, 2'b00, 8'h02);
        step("t6e", 0, '0, 1, 2'b00, 8'h03);
        chk("t6.notfull", 64'(full), 64'h0);
        step("t6f", 0, '0, 1, 2'b00, 8'h04);
        chk("t6.full", 64'(full),   64'h1);
        chk("t6.st",   64'(stages), 64'h01020304);

        // 3b. odd depth: last stage holds on swap
        load3 = 1'b1; load_data3 = 24'h030201;
        @(posedge clk); #1;
        load3 = 1'b0; en3 = 1'b1; mode3 = 2'b10;
        @(posedge clk); #1;
        en3 = 1'b0;
        chk("t3odd.st",   64'(stages3),   64'h030102);
        chk("t3odd.full", 64'(full3),     64'h1);

        // 7. default two-flop chain: 2-edge delay
        en1 = 1'b1; mode1 = 2'b00; din1 = 1'b1;
        @(posedge clk); #1;
        chk("t7.e1.dout", 64'(dout1), 64'h0);
        chk("t7.e1.fill", 64'(fill_cnt1), 64'h1);
        din1 = 1'b0;
        @(posedge clk); #1;
        chk("t7.e2.dout", 64'(dout1), 64'h1);
        chk("t7.e2.full", 64'(full1), 64'h1);
        @(posedge clk); #1;
        chk("t7.e3.dout", 64'(dout1), 64'h0);
        en1 = 1'b0;

        chk("sb.empty", 64'(sb_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
